// File: rtl/fifo_pkg.sv
// Shared definitions for the arbitrated FIFO write/read controller:
// default sizing and the read-side FSM state encoding.
package fifo_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_BURST = 4;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_BURST = 2'd1,
        RD_FLUSH = 2'd2
    } rd_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the search starts one past last_grant,
// wraps at NREQ-1, and the first asserted request wins.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int LGW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [LGW-1:0]  last_grant,
    input  logic            enable,
    output logic [NREQ-1:0] grant
);

    logic           found;
    logic [LGW-1:0] idx;

    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = LGW'((int'(last_grant) + k) % NREQ);
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arb_ctrl.sv
// FIFO controller: round-robin write arbitration among NREQ requesters and a
// burst/flush read sequencer, with controller-side occupancy tracking.
module fifo_arb_ctrl
    import fifo_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int BURST = DEF_BURST
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DW-1:0]     data,
    output logic [NREQ-1:0]        gnt,
    output logic                   fifo_wr,
    output logic [DW-1:0]          fifo_din,
    output logic                   fifo_rd,
    input  logic                   drain_req,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy_rd
);

    localparam int LW  = $clog2(DEPTH) + 1;
    localparam int LGW = (NREQ > 1) ? $clog2(NREQ) : 1;

    rd_state_t       state, state_next;
    logic [LW-1:0]   burst_cnt, burst_cnt_next;
    logic [LW-1:0]   level_net, level_next;
    logic [LGW-1:0]  last_grant, gnt_idx;
    logic [NREQ-1:0] arb_grant;
    logic            rd_issue, wr_issue, wr_enable;
    logic            run;

    // Read sequencer: decides this cycle's read, registered onto fifo_rd.
    always_comb begin
        state_next     = state;
        burst_cnt_next = burst_cnt;
        rd_issue       = 1'b0;
        case (state)
            RD_IDLE: begin
                if (run) begin
                    if (flush && level != '0) begin
                        state_next = RD_FLUSH;
                    end else if (drain_req && level >= LW'(BURST)) begin
                        state_next     = RD_BURST;
                        burst_cnt_next = LW'(BURST);
                    end
                end
            end
            RD_BURST: begin
                rd_issue       = (level != '0);
                burst_cnt_next = burst_cnt - LW'(1);
                if (burst_cnt <= LW'(1)) begin
                    state_next     = RD_IDLE;
                    burst_cnt_next = '0;
                end
            end
            RD_FLUSH: begin
                rd_issue = (level != '0);
                if (level <= LW'(1)) state_next = RD_IDLE;
            end
            default: state_next = RD_IDLE;
        endcase
    end

    // A write may reuse the slot freed by a read issued in the same cycle.
    assign level_net = level - LW'(rd_issue);
    assign wr_enable = run && (state != RD_FLUSH) && (level_net < LW'(DEPTH));

    rr_arbiter #(
        .NREQ (NREQ),
        .LGW  (LGW)
    ) u_rr_arbiter (
        .req        (req),
        .last_grant (last_grant),
        .enable     (wr_enable),
        .grant      (arb_grant)
    );

    always_comb begin
        gnt_idx = last_grant;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) gnt_idx = LGW'(i);
        end
    end

    assign wr_issue   = |arb_grant;
    assign level_next = level + LW'(wr_issue) - LW'(rd_issue);
    assign busy_rd    = (state != RD_IDLE);

    // run holds arbitration off for the first edge after reset release.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run        <= 1'b0;
            state      <= RD_IDLE;
            burst_cnt  <= '0;
            level      <= '0;
            last_grant <= LGW'(NREQ - 1);
            gnt        <= '0;
            fifo_wr    <= 1'b0;
            fifo_din   <= '0;
            fifo_rd    <= 1'b0;
        end else begin
            run       <= 1'b1;
            state     <= state_next;
            burst_cnt <= burst_cnt_next;
            level     <= level_next;
            gnt       <= arb_grant;
            fifo_wr   <= wr_issue;
            fifo_din  <= wr_issue ? data[int'(gnt_idx)*DW +: DW] : '0;
            fifo_rd   <= rd_issue;
            if (wr_issue) last_grant <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Directed bench for fifo_arb_ctrl: a vector table for the main flows plus
// hand sequences for flush, reset mid-burst and the near-full burst case.
module tb_fifo_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] data = 32'h4433_2211;
    logic [3:0]  gnt;
    logic        fifo_wr;
    logic [7:0]  fifo_din;
    logic        fifo_rd;
    logic        drain_req = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  level;
    logic        busy_rd;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       drain;
        logic       flush;
        logic [3:0] gnt;
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic [3:0] lvl;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    fifo_arb_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .fifo_rd   (fifo_rd),
        .drain_req (drain_req),
        .flush     (flush),
        .level     (level),
        .busy_rd   (busy_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic dr, input logic fl,
                       input logic [3:0] g, input logic w, input logic [7:0] d,
                       input logic rd, input logic [3:0] l, input logic b);
        vec_t v;
        v = '{rst: r, req: rq, drain: dr, flush: fl, gnt: g, wr: w, din: d,
              rd: rd, lvl: l, busy: b};
        vecs.push_back(v);
    endtask

    // Protocol monitor: occupancy bookkeeping and no write-when-full / read-when-empty.
    int prev_level = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_level = 0;
        end else begin
            check("mon_level_step", 32'(level), 32'(prev_level + int'(fifo_wr) - int'(fifo_rd)));
            if (fifo_wr && !fifo_rd) check("mon_wr_not_full", 32'(prev_level < 8), 32'd1);
            if (fifo_rd) check("mon_rd_not_empty", 32'(prev_level > 0), 32'd1);
            prev_level = int'(level);
        end
    end

    initial begin
        int rd_count;

        //   rst  req     dr  fl   gnt     wr  din    rd  lvl  busy
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);  // reset state
        add(0, 4'b1111, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);  // first edge after release: no grant
        add(0, 4'b1111, 0, 0, 4'b0001, 1, 8'h11, 0, 1, 0);
        add(0, 4'b1111, 0, 0, 4'b0010, 1, 8'h22, 0, 2, 0);
        add(0, 4'b1111, 0, 0, 4'b0100, 1, 8'h33, 0, 3, 0);
        add(0, 4'b1111, 0, 0, 4'b1000, 1, 8'h44, 0, 4, 0);
        add(0, 4'b1111, 0, 0, 4'b0001, 1, 8'h11, 0, 5, 0);  // wraps back to requester 0
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        add(0, 4'b0101, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0);
        add(0, 4'b0101, 0, 0, 4'b0001, 1, 8'h11, 0, 1, 0);
        add(0, 4'b0101, 0, 0, 4'b0100, 1, 8'h33, 0, 2, 0);
        add(0, 4'b0101, 0, 0, 4'b0001, 1, 8'h11, 0, 3, 0);
        add(0, 4'b0101, 0, 0, 4'b0100, 1, 8'h33, 0, 4, 0);
        add(0, 4'b0101, 0, 0, 4'b0001, 1, 8'h11, 0, 5, 0);
        add(0, 4'b0101, 0, 0, 4'b0100, 1, 8'h33, 0, 6, 0);
        add(0, 4'b0101, 0, 0, 4'b0001, 1, 8'h11, 0, 7, 0);
        add(0, 4'b0101, 0, 0, 4'b0100, 1, 8'h33, 0, 8, 0);
        add(0, 4'b0101, 0, 0, 4'b0000, 0, 8'h00, 0, 8, 0);  // full: no grant
        add(0, 4'b0000, 1, 0, 4'b0000, 0, 8'h00, 0, 8, 1);  // burst starts
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 1, 7, 1);  // drain_req dropped, burst continues
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 1, 6, 1);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 8'h00, 1, 5, 1);  // flush ignored mid-burst
        add(0, 4'b0010, 0, 0, 4'b0010, 1, 8'h22, 1, 5, 0);  // write in last burst cycle
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 5, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 0, 8'h00, 0, 5, 1);  // flush starts
        add(0, 4'b0001, 0, 0, 4'b0000, 0, 8'h00, 1, 4, 1);  // writes blocked while flushing
        add(0, 4'b0001, 0, 0, 4'b0000, 0, 8'h00, 1, 3, 1);
        add(0, 4'b0001, 0, 0, 4'b0000, 0, 8'h00, 1, 2, 1);
        add(0, 4'b0001, 0, 0, 4'b0000, 0, 8'h00, 1, 1, 1);
        add(0, 4'b0001, 0, 0, 4'b0000, 0, 8'h00, 1, 0, 0);
        add(0, 4'b0001, 0, 0, 4'b0001, 1, 8'h11, 0, 1, 0);  // writes resume
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 8'h00, 0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst       = vecs[i].rst;
            req       = vecs[i].req;
            drain_req = vecs[i].drain;
            flush     = vecs[i].flush;
            tick();
            check($sformatf("v%0d gnt", i),   32'(gnt),      32'(vecs[i].gnt));
            check($sformatf("v%0d wr", i),    32'(fifo_wr),  32'(vecs[i].wr));
            check($sformatf("v%0d din", i),   32'(fifo_din), 32'(vecs[i].din));
            check($sformatf("v%0d rd", i),    32'(fifo_rd),  32'(vecs[i].rd));
            check($sformatf("v%0d level", i), 32'(level),    32'(vecs[i].lvl));
            check($sformatf("v%0d busy", i),  32'(busy_rd),  32'(vecs[i].busy));
        end

        // Flush from level 3 with no requests: exactly three reads.
        req = 4'b0001;
        tick();
        tick();
        check("flush_pre_level", 32'(level), 32'd3);
        req   = 4'b0000;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        rd_count = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (fifo_rd) rd_count++;
        end
        check("flush_rd_count", 32'(rd_count), 32'd3);
        check("flush_level", 32'(level), 32'd0);
        check("flush_busy", 32'(busy_rd), 32'd0);

        // Reset asserted in the second burst cycle.
        req = 4'b1111;
        repeat (4) tick();
        req       = 4'b0000;
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        tick();
        check("rstb_in_burst", 32'(busy_rd), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstb_outs", {gnt, fifo_wr, fifo_din, fifo_rd, busy_rd}, 32'd0);
        check("rstb_level", 32'(level), 32'd0);
        tick();
        rst = 1'b0;
        req = 4'b1000;
        tick();
        check("rstb_no_early_gnt", 32'(gnt), 32'd0);
        tick();
        check("rstb_first_gnt", 32'(gnt), 32'b1000);
        check("rstb_first_din", 32'(fifo_din), 32'h44);

        // Level 7: a burst with a concurrent write every cycle holds at 7.
        repeat (6) tick();
        req = 4'b0000;
        check("near_full_level", 32'(level), 32'd7);
        drain_req = 1'b1;
        tick();
        drain_req = 1'b0;
        req       = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("nf%0d rd", c),    32'(fifo_rd), 32'd1);
            check($sformatf("nf%0d wr", c),    32'(fifo_wr), 32'd1);
            check($sformatf("nf%0d level", c), 32'(level),   32'd7);
        end
        req = 4'b0000;
        tick();
        check("nf_end_level", 32'(level), 32'd7);
        check("nf_end_busy", 32'(busy_rd), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
